// File: rtl/golomb_job_scheduler_if.sv
// golomb_job_scheduler_if: host job/result link plus assembly control bundle.
interface golomb_job_scheduler_if #(
  parameter int NUMPOSITIONS = 5,
  parameter int PVBITS       = 9
);
  localparam int VEC_W = (NUMPOSITIONS + 1) * PVBITS;
  logic              job_valid;
  logic              job_ready;
  logic [VEC_W-1:0]  job_prefix;
  logic              job_abort;
  logic              asm_reset;
  logic [VEC_W-1:0]  asm_firstvalues;
  logic [VEC_W-1:0]  asm_marks;
  logic [5:0]        asm_numresults;
  logic              asm_done;
  logic              res_valid;
  logic              res_ready;
  logic [VEC_W-1:0]  res_marks;
  logic [5:0]        res_count;
  logic              res_timeout;
  logic              res_aborted;
  logic [PVBITS-1:0] best_len;
  logic [15:0]       jobs_done;
  logic              busy;
  modport master (
    output job_valid, job_prefix, job_abort, asm_marks, asm_numresults, asm_done, res_ready,
    input  job_ready, asm_reset, asm_firstvalues, res_valid, res_marks, res_count,
           res_timeout, res_aborted, best_len, jobs_done, busy
  );
  modport slave (
    input  job_valid, job_prefix, job_abort, asm_marks, asm_numresults, asm_done, res_ready,
    output job_ready, asm_reset, asm_firstvalues, res_valid, res_marks, res_count,
           res_timeout, res_aborted, best_len, jobs_done, busy
  );
endinterface

// File: rtl/golomb_job_scheduler.sv
// golomb_job_scheduler: runs one mark_counter_assembly per buffered job under a watchdog.
module golomb_job_scheduler #(
  parameter int NUMPOSITIONS = 5,
  parameter int PVBITS       = 9,
  parameter int RESET_HOLD   = 4,
  parameter int WDOG_W       = 24
) (
  input logic FXCLK,
  input logic RESET_IN_N,
  golomb_job_scheduler_if.slave bus
);
  localparam int VEC_W = (NUMPOSITIONS + 1) * PVBITS;
  localparam int CW    = $clog2(RESET_HOLD);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;
  state_t            state, state_nx;
  logic              buf_full;
  logic [VEC_W-1:0]  job_buf, firstvalues, res_marks;
  logic [CW-1:0]     cnt;
  logic [WDOG_W-1:0] wd;
  logic [5:0]        res_count;
  logic              res_timeout, res_aborted;
  logic [PVBITS-1:0] best_len, last_mark;
  logic [15:0]       jobs_done;
  logic              done_hit, abort_hit, tmo_hit, finish;
  // wd==0 marks the first RUN cycle, where a stale asm_done is ignored
  assign last_mark = bus.asm_marks[NUMPOSITIONS*PVBITS +: PVBITS];
  assign done_hit  = state == RUN && bus.asm_done && |wd;
  assign abort_hit = state == RUN && bus.job_abort;
  assign tmo_hit   = state == RUN && &wd;
  assign finish    = done_hit || abort_hit || tmo_hit;
  always_ff @(posedge FXCLK or negedge RESET_IN_N)
    if (!RESET_IN_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = buf_full ? LOAD : IDLE;
      LOAD:    state_nx = cnt == CW'(RESET_HOLD - 1) ? RUN : LOAD;
      RUN:     state_nx = finish ? REPORT : RUN;
      REPORT:  state_nx = bus.res_ready ? IDLE : REPORT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge FXCLK or negedge RESET_IN_N)
    if (!RESET_IN_N) begin
      buf_full    <= 1'b0;
      job_buf     <= '0;
      firstvalues <= '0;
      cnt         <= '0;
      wd          <= '0;
      res_marks   <= '0;
      res_count   <= '0;
      res_timeout <= 1'b0;
      res_aborted <= 1'b0;
      best_len    <= '1;
      jobs_done   <= '0;
    end else begin
      if (bus.job_valid && !buf_full) begin
        buf_full <= 1'b1;
        job_buf  <= bus.job_prefix;
      end
      if (state == IDLE && buf_full) begin
        buf_full    <= 1'b0;
        firstvalues <= job_buf;
      end
      cnt <= state == LOAD ? cnt + CW'(1) : '0;
      wd  <= state == RUN ? wd + WDOG_W'(1) : '0;
      if (finish) begin
        res_marks   <= bus.asm_marks;
        res_count   <= bus.asm_numresults;
        res_timeout <= !done_hit && !abort_hit;
        res_aborted <= !done_hit && abort_hit;
        jobs_done   <= jobs_done + 16'd1;
        if (done_hit && bus.asm_numresults != 6'd0 && last_mark < best_len) best_len <= last_mark;
      end
    end
  assign bus.job_ready       = !buf_full;
  assign bus.asm_reset       = state != RUN;
  assign bus.asm_firstvalues = firstvalues;
  assign bus.res_valid       = state == REPORT;
  assign bus.res_marks       = res_marks;
  assign bus.res_count       = res_count;
  assign bus.res_timeout     = res_timeout;
  assign bus.res_aborted     = res_aborted;
  assign bus.best_len        = best_len;
  assign bus.jobs_done       = jobs_done;
  assign bus.busy            = state != IDLE;
endmodule
